// File: rtl/axi_lite_slave_buf.sv
// rtl/axi_lite_slave_buf.sv - AXI4-Lite slave with registered handshakes, user strobe bus and range decode
// Optional feature macro: AXIL_SLV_UNALIGNED_ERR_EN (misaligned addresses answered with SLVERR).
module axi_lite_slave_buf #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    ADDR_SPAN  = 4096,
  parameter int                    RD_LATENCY = 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [ADDR_WIDTH-1:0]   user_wr_addr,
  output logic [DATA_WIDTH-1:0]   user_wr_data,
  output logic [DATA_WIDTH/8-1:0] user_wr_strb,
  output logic                    user_wr_en,
  input  logic [1:0]              user_wr_resp,
  output logic [ADDR_WIDTH-1:0]   user_rd_addr,
  output logic                    user_rd_en,
  input  logic [DATA_WIDTH-1:0]   user_rd_data,
  input  logic [1:0]              user_rd_resp
);
  localparam int                    STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] SPAN_MASK  = ~ADDR_WIDTH'(ADDR_SPAN - 1);
`ifdef AXIL_SLV_UNALIGNED_ERR_EN
  localparam int                    LSB        = $clog2(STRB_WIDTH);
`endif

  // DECERR is evaluated last so it overrides SLVERR.
  function automatic logic [1:0] access_err(input logic [ADDR_WIDTH-1:0] addr);
    logic [1:0] err;
    err = 2'b00;
`ifdef AXIL_SLV_UNALIGNED_ERR_EN
    if (addr[LSB-1:0] != '0) err = 2'b10;
`endif
    if ((addr & SPAN_MASK) != BASE_ADDR) err = 2'b11;
    return err;
  endfunction

  logic                  aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  wr_fire_q, wr_fire_d;
  logic [1:0]            wr_err_q, wr_err_d;
  logic                  user_wr_en_q, user_wr_en_d;
  logic [ADDR_WIDTH-1:0] user_wr_addr_q, user_wr_addr_d;
  logic [DATA_WIDTH-1:0] user_wr_data_q, user_wr_data_d;
  logic [STRB_WIDTH-1:0] user_wr_strb_q, user_wr_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  ar_full_q, ar_full_d, rd_issued_q, rd_issued_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic                  arready_q, arready_d;
  logic [1:0]            rd_err_q, rd_err_d;
  logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic                  user_rd_en_q, user_rd_en_d;
  logic [ADDR_WIDTH-1:0] user_rd_addr_q, user_rd_addr_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rd_fire;

  always_comb begin
    aw_full_d      = aw_full_q;
    aw_addr_d      = aw_addr_q;
    w_full_d       = w_full_q;
    w_data_d       = w_data_q;
    w_strb_d       = w_strb_q;
    wr_err_d       = wr_err_q;
    user_wr_en_d   = 1'b0;
    user_wr_addr_d = user_wr_addr_q;
    user_wr_data_d = user_wr_data_q;
    user_wr_strb_d = user_wr_strb_q;
    bvalid_d       = bvalid_q;
    bresp_d        = bresp_q;
    ar_full_d      = ar_full_q;
    ar_addr_d      = ar_addr_q;
    rd_issued_d    = rd_issued_q;
    rd_err_d       = rd_err_q;
    user_rd_en_d   = 1'b0;
    user_rd_addr_d = user_rd_addr_q;
    rvalid_d       = rvalid_q;
    rdata_d        = rdata_q;
    rresp_d        = rresp_q;

    if (awvalid && awready_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = awaddr;
    end
    if (wvalid && wready_q) begin
      w_full_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end

    // A fire token is issued even for rejected accesses so every response has the same latency.
    wr_fire_d = aw_full_q && w_full_q && !bvalid_q && !wr_fire_q;
    if (wr_fire_d) begin
      wr_err_d = access_err(aw_addr_q);
      if (access_err(aw_addr_q) == 2'b00) begin
        user_wr_en_d   = 1'b1;
        user_wr_addr_d = aw_addr_q;
        user_wr_data_d = w_data_q;
        user_wr_strb_d = w_strb_q;
      end
    end
    if (wr_fire_q) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = (wr_err_q != 2'b00) ? wr_err_q : user_wr_resp;
    end
    if (bvalid_q && bready) bvalid_d = 1'b0;

    if (arvalid && arready_q) begin
      ar_full_d = 1'b1;
      ar_addr_d = araddr;
    end
    rd_fire = ar_full_q && !rd_issued_q;
    if (rd_fire) begin
      rd_issued_d = 1'b1;
      rd_err_d    = access_err(ar_addr_q);
      if (access_err(ar_addr_q) == 2'b00) begin
        user_rd_en_d   = 1'b1;
        user_rd_addr_d = ar_addr_q;
      end
    end
    rd_pipe_d = (rd_pipe_q << 1) | RD_LATENCY'(rd_fire);
    if (rd_pipe_q[RD_LATENCY-1]) begin
      rvalid_d = 1'b1;
      rdata_d  = (rd_err_q != 2'b00) ? '0 : user_rd_data;
      rresp_d  = (rd_err_q != 2'b00) ? rd_err_q : user_rd_resp;
    end
    if (rvalid_q && rready) begin
      rvalid_d    = 1'b0;
      ar_full_d   = 1'b0;
      rd_issued_d = 1'b0;
    end

    awready_d = !aw_full_d;
    wready_d  = !w_full_d;
    arready_d = !ar_full_d;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_full_q      <= 1'b0;
      aw_addr_q      <= '0;
      w_full_q       <= 1'b0;
      w_data_q       <= '0;
      w_strb_q       <= '0;
      awready_q      <= 1'b0;
      wready_q       <= 1'b0;
      wr_fire_q      <= 1'b0;
      wr_err_q       <= 2'b00;
      user_wr_en_q   <= 1'b0;
      user_wr_addr_q <= '0;
      user_wr_data_q <= '0;
      user_wr_strb_q <= '0;
      bvalid_q       <= 1'b0;
      bresp_q        <= 2'b00;
      ar_full_q      <= 1'b0;
      ar_addr_q      <= '0;
      rd_issued_q    <= 1'b0;
      arready_q      <= 1'b0;
      rd_err_q       <= 2'b00;
      rd_pipe_q      <= '0;
      user_rd_en_q   <= 1'b0;
      user_rd_addr_q <= '0;
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
      rresp_q        <= 2'b00;
    end else begin
      aw_full_q      <= aw_full_d;
      aw_addr_q      <= aw_addr_d;
      w_full_q       <= w_full_d;
      w_data_q       <= w_data_d;
      w_strb_q       <= w_strb_d;
      awready_q      <= awready_d;
      wready_q       <= wready_d;
      wr_fire_q      <= wr_fire_d;
      wr_err_q       <= wr_err_d;
      user_wr_en_q   <= user_wr_en_d;
      user_wr_addr_q <= user_wr_addr_d;
      user_wr_data_q <= user_wr_data_d;
      user_wr_strb_q <= user_wr_strb_d;
      bvalid_q       <= bvalid_d;
      bresp_q        <= bresp_d;
      ar_full_q      <= ar_full_d;
      ar_addr_q      <= ar_addr_d;
      rd_issued_q    <= rd_issued_d;
      arready_q      <= arready_d;
      rd_err_q       <= rd_err_d;
      rd_pipe_q      <= rd_pipe_d;
      user_rd_en_q   <= user_rd_en_d;
      user_rd_addr_q <= user_rd_addr_d;
      rvalid_q       <= rvalid_d;
      rdata_q        <= rdata_d;
      rresp_q        <= rresp_d;
    end
  end

  assign awready      = awready_q;
  assign wready       = wready_q;
  assign bvalid       = bvalid_q;
  assign bresp        = bresp_q;
  assign arready      = arready_q;
  assign rvalid       = rvalid_q;
  assign rdata        = rdata_q;
  assign rresp        = rresp_q;
  assign user_wr_en   = user_wr_en_q;
  assign user_wr_addr = user_wr_addr_q;
  assign user_wr_data = user_wr_data_q;
  assign user_wr_strb = user_wr_strb_q;
  assign user_rd_en   = user_rd_en_q;
  assign user_rd_addr = user_rd_addr_q;
endmodule

// File: tb/tb_axi_lite_slave_buf.sv
// tb/tb_axi_lite_slave_buf.sv - self-checking bench for axi_lite_slave_buf (RD_LATENCY=3, default build)
module tb_axi_lite_slave_buf;
  localparam logic [31:0] BASE = 32'h0;
  localparam int          SPAN = 4096;
  localparam int          LAT  = 3;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata, user_wr_addr, user_wr_data, user_rd_addr;
  logic [31:0] user_rd_data = '0;
  logic [3:0]  wstrb = '0, user_wr_strb;
  logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic        arvalid = 0, arready, rvalid, rready = 0, user_wr_en, user_rd_en;
  logic [1:0]  bresp, rresp, user_wr_resp = '0, user_rd_resp = '0;

  always #5 aclk = ~aclk;

  axi_lite_slave_buf #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE), .ADDR_SPAN(SPAN), .RD_LATENCY(LAT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .user_wr_addr(user_wr_addr), .user_wr_data(user_wr_data), .user_wr_strb(user_wr_strb),
    .user_wr_en(user_wr_en), .user_wr_resp(user_wr_resp),
    .user_rd_addr(user_rd_addr), .user_rd_en(user_rd_en),
    .user_rd_data(user_rd_data), .user_rd_resp(user_rd_resp)
  );

  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] ref_mem  [0:1023];
  logic [31:0] user_mem [0:1023];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic bit in_range(input logic [31:0] a);
    longint unsigned x;
    x = 64'(a);
    return (x >= 64'(BASE)) && (x < 64'(BASE) + 64'(SPAN));
  endfunction

  function automatic int idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[11:2]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic user_write();
    if (user_wr_en) user_mem[idx(user_wr_addr)] = merge(user_mem[idx(user_wr_addr)], user_wr_data, user_wr_strb);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] uresp, input int aw_dly, input int w_dly, input int b_dly,
                          input bit leave_b);
    bit aw_done, w_done, hs_aw, hs_w, exp_en;
    logic [1:0] exp_resp;
    int t;
    exp_en = in_range(addr);
    exp_resp = exp_en ? uresp : 2'b11;
    aw_done = 0; w_done = 0; t = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    user_wr_resp = ~uresp;
    while (!(aw_done && w_done) && t < 40) begin
      awvalid = !aw_done && (t >= aw_dly);
      wvalid  = !w_done && (t >= w_dly);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick();
      t++;
      if (hs_aw) aw_done = 1;
      if (hs_w) w_done = 1;
      chk("wr_no_early_en", user_wr_en, 1'b0);
    end
    awvalid = 0; wvalid = 0;
    chk("wr_handshake", aw_done && w_done, 1'b1);
    if (exp_en) ref_mem[idx(addr)] = merge(ref_mem[idx(addr)], data, strb);
    tick();
    user_wr_resp = uresp;
    chk("wr_en", user_wr_en, exp_en);
    if (exp_en) begin
      chk("wr_addr", user_wr_addr, addr);
      chk("wr_data", user_wr_data, data);
      chk("wr_strb", user_wr_strb, strb);
    end
    user_write();
    chk("wr_ready_busy", {awready, wready}, 2'b00);
    chk("wr_bvalid_early", bvalid, 1'b0);
    tick();
    user_wr_resp = ~uresp;
    chk("wr_en_one_cycle", user_wr_en, 1'b0);
    chk("wr_bvalid", bvalid, 1'b1);
    chk("wr_bresp", bresp, exp_resp);
    chk("wr_ready_free", {awready, wready}, 2'b11);
    if (!leave_b) begin
      for (int i = 0; i < b_dly; i++) begin
        tick();
        chk("wr_b_hold", {bvalid, bresp}, {1'b1, exp_resp});
        chk("wr_no_refire", user_wr_en, 1'b0);
      end
      bready = 1; tick(); bready = 0;
      chk("wr_bvalid_clr", bvalid, 1'b0);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [1:0] uresp, input int ar_dly, input int r_dly);
    bit done, hs, exp_en, seen;
    logic [31:0] exp_data, seen_addr;
    logic [1:0] exp_resp;
    int t;
    exp_en = in_range(addr);
    exp_data = exp_en ? ref_mem[idx(addr)] : 32'h0;
    exp_resp = exp_en ? uresp : 2'b11;
    done = 0; t = 0;
    araddr = addr;
    while (!done && t < 40) begin
      arvalid = (t >= ar_dly);
      hs = arvalid && arready;
      user_rd_data = $urandom; user_rd_resp = ~uresp;
      tick();
      t++;
      if (hs) done = 1;
      chk("rd_no_early_en", user_rd_en, 1'b0);
    end
    arvalid = 0;
    chk("rd_handshake", done, 1'b1);
    tick();
    seen = user_rd_en; seen_addr = user_rd_addr;
    chk("rd_en", user_rd_en, exp_en);
    if (exp_en) chk("rd_addr", user_rd_addr, addr);
    for (int k = 1; k <= LAT; k++) begin
      if (k == LAT && seen) begin
        user_rd_data = user_mem[idx(seen_addr)]; user_rd_resp = uresp;
      end else begin
        user_rd_data = $urandom; user_rd_resp = ~uresp;
      end
      chk("rd_rvalid_early", rvalid, 1'b0);
      chk("rd_arready_busy", arready, 1'b0);
      tick();
      chk("rd_en_one_cycle", user_rd_en, 1'b0);
    end
    chk("rd_rvalid", rvalid, 1'b1);
    chk("rd_rdata", rdata, exp_data);
    chk("rd_rresp", rresp, exp_resp);
    for (int i = 0; i < r_dly; i++) begin
      user_rd_data = $urandom; user_rd_resp = ~uresp;
      tick();
      chk("rd_r_hold", {rvalid, rresp, rdata}, {1'b1, exp_resp, exp_data});
    end
    rready = 1; tick(); rready = 0;
    chk("rd_rvalid_clr", rvalid, 1'b0);
    chk("rd_arready_back", arready, 1'b1);
  endtask

  logic [31:0] a, rd_word;

  initial begin
    for (int i = 0; i < 1024; i++) begin ref_mem[i] = '0; user_mem[i] = '0; end

    tick(); tick();
    chk("rst_readies", {awready, wready, arready}, 3'b000);
    chk("rst_valids", {bvalid, rvalid, user_wr_en, user_rd_en}, 4'b0000);
    chk("rst_data", {rdata, user_wr_data}, 64'h0);
    chk("rst_resp_addr", {bresp, rresp, user_wr_addr[15:0], user_rd_addr[15:0], user_wr_strb}, 40'h0);
    aresetn = 1;
    tick();
    chk("rst_release_readies", {awready, wready, arready}, 3'b111);

    do_write(32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0, 0, 0);
    do_write(32'h20, 32'hCAFEF00D, 4'h3, 2'b01, 3, 0, 5, 0);
    do_write(32'h24, 32'h11112222, 4'hF, 2'b00, 0, 0, 0, 1);
    user_wr_resp = 2'b11;
    awvalid = 1; awaddr = 32'h28; wvalid = 1; wdata = 32'h33334444; wstrb = 4'hC;
    tick();
    awvalid = 0; wvalid = 0;
    chk("ovl_accept", {awready, wready}, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ovl_no_fire", user_wr_en, 1'b0);
      chk("ovl_b_hold", {bvalid, bresp}, 3'b100);
    end
    bready = 1; tick(); bready = 0;
    chk("ovl_b_done", bvalid, 1'b0);
    chk("ovl_wait", user_wr_en, 1'b0);
    user_wr_resp = 2'b01;
    tick();
    chk("ovl_fire", user_wr_en, 1'b1);
    chk("ovl_fields", {user_wr_addr, user_wr_data}, {32'h28, 32'h33334444});
    chk("ovl_strb", user_wr_strb, 4'hC);
    user_write();
    ref_mem[idx(32'h28)] = merge(ref_mem[idx(32'h28)], 32'h33334444, 4'hC);
    tick();
    user_wr_resp = 2'b11;
    chk("ovl_bresp", {bvalid, bresp}, 3'b101);
    bready = 1; tick(); bready = 0;
    chk("ovl_b2_done", bvalid, 1'b0);

    do_write(32'h8, 32'h12345678, 4'hF, 2'b00, 0, 1, 0, 0);
    do_read(32'h8, 2'b00, 0, 0);
    do_read(32'h20, 2'b00, 1, 2);
    do_read(32'h2000, 2'b00, 0, 1);
    do_write(32'h1000, 32'hFFFF0000, 4'hF, 2'b00, 0, 0, 1, 0);
    do_read(32'hFFC, 2'b00, 0, 0);
    do_write(32'h6, 32'h0BADF00D, 4'h5, 2'b01, 0, 0, 0, 0);
    do_write(32'h40, 32'h55555555, 4'h0, 2'b10, 1, 0, 0, 0);
    do_read(32'h40, 2'b00, 0, 0);

    awvalid = 1; awaddr = 32'h34; wvalid = 1; wdata = 32'hA5A50F0F; wstrb = 4'hF;
    arvalid = 1; araddr = 32'h20; user_wr_resp = 2'b00;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    tick();
    chk("par_en", {user_wr_en, user_rd_en}, 2'b11);
    user_write();
    ref_mem[idx(32'h34)] = 32'hA5A50F0F;
    rd_word = user_mem[idx(user_rd_addr)];
    user_rd_data = $urandom; user_rd_resp = 2'b01;
    tick();
    chk("par_bvalid", {bvalid, bresp, rvalid}, 4'b1000);
    tick();
    user_rd_data = rd_word; user_rd_resp = 2'b00;
    tick();
    chk("par_r", {rvalid, rresp}, 3'b100);
    chk("par_rdata", rdata, ref_mem[idx(32'h20)]);
    bready = 1; rready = 1; tick(); bready = 0; rready = 0;
    chk("par_done", {bvalid, rvalid}, 2'b00);

    arvalid = 1; araddr = 32'h8;
    tick();
    arvalid = 0;
    tick();
    chk("rst_mid_rd_en", user_rd_en, 1'b1);
    aresetn = 0;
    tick();
    chk("rst_mid_readies", {awready, wready, arready}, 3'b000);
    chk("rst_mid_valids", {rvalid, bvalid}, 2'b00);
    aresetn = 1;
    tick();
    chk("rst_mid_arready", arready, 1'b1);
    for (int i = 0; i < LAT + 3; i++) begin
      user_rd_data = $urandom;
      tick();
      chk("rst_mid_no_rvalid", {rvalid, user_rd_en}, 2'b00);
    end

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom | 32'h1000;
      else a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3) == 0 ? 1 : 0);
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, 4'($urandom), 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), 0);
      else
        do_read(a, 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_slave_buf.md
# axi_lite_slave_buf

Second-generation AXI4-Lite slave protocol controller with buffered handshakes, a configurable user read latency and address-range decode. It sits between an AXI4-Lite interconnect port and a local register file or memory, converting AXI transactions into single-cycle user write/read strobes. All AXI ready/valid outputs are registered, so the block can be placed on timing-critical boundaries. Out-of-range accesses are answered with DECERR without touching user logic.

## Interface
- ADDR_WIDTH, 32, AXI/user address width
- DATA_WIDTH, 32, data width; 32 or 64
- BASE_ADDR, 0, first byte address decoded by this slave
- ADDR_SPAN, 4096, decoded window size in bytes; power of two, BASE_ADDR aligned to it
- RD_LATENCY, 1, cycles from user_rd_en high to user_rd_data valid; 1..4
- aclk  in  1  clock; single clock domain
- aresetn  in  1  reset, synchronous, active-low
- awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite channels; widths ADDR_WIDTH, DATA_WIDTH, DATA_WIDTH/8, 2
- user_wr_addr  out  ADDR_WIDTH  write byte address (absolute)
- user_wr_data  out  DATA_WIDTH  write data
- user_wr_strb  out  DATA_WIDTH/8  byte strobes
- user_wr_en  out  1  one-cycle write pulse
- user_wr_resp  in  2  sampled in the cycle user_wr_en is high
- user_rd_addr  out  ADDR_WIDTH  read byte address
- user_rd_en  out  1  one-cycle read pulse
- user_rd_data  in  DATA_WIDTH  sampled RD_LATENCY cycles after user_rd_en
- user_rd_resp  in  2  sampled with user_rd_data

## Operation
- Reset: every output 0 (including awready, wready, arready); readies go 1 on the first edge with aresetn high.
- Write path: one-entry AW slot and one-entry W slot, filled independently in any order; awready = slot empty, wready = slot empty (registered).
- Write fire: both slots full and bvalid low -> user_wr_en pulses one cycle with slot contents on user_wr_*; in-range required.
- Out-of-range write (awaddr outside [BASE_ADDR, BASE_ADDR+ADDR_SPAN)): no user_wr_en; bresp = 2'b11.
- wstrb = 0: user_wr_en still pulses with zero strobe; response from user_wr_resp.
- B channel: bvalid/bresp held stable until bready; slots may refill while bvalid high, next fire waits for bvalid low.
- Read path: one-entry AR slot; single read outstanding; arready low from AR handshake until R handshake completes.
- Read fire: user_rd_en one cycle, user_rd_addr valid same cycle; latency shift register of RD_LATENCY stages captures user_rd_data/user_rd_resp into rdata/rresp, rvalid held until rready.
- Out-of-range read: no user_rd_en; after the same latency rdata = 0, rresp = 2'b11.
- Read and write paths fully independent; user_wr_en and user_rd_en may pulse in the same cycle.
- Synchronous reset mid-transaction: all slots, pipeline and valids cleared at that edge; in-flight access abandoned, no response issued.

## Timing
- AW and W handshake at edge E0 -> user_wr_en high in cycle after E1 -> bvalid high from E2 (2 cycles handshake-to-bvalid).
- Slots free at E2; awready/wready high from E2.
- AR handshake at E0 -> user_rd_en high after E1 -> rvalid from edge E1+RD_LATENCY.
- R handshake at edge Er -> arready high from Er; min read issue interval RD_LATENCY+3 cycles.
- bvalid/rvalid never depend combinationally on bready/rready; no combinational AXI input-to-output path.

## Configuration
- AXIL_SLV_UNALIGNED_ERR_EN defined: address with nonzero low log2(DATA_WIDTH/8) bits gets SLVERR (2'b10), no user strobe, same latency as a normal access; DECERR takes priority over SLVERR.
- Undefined: low address bits passed unchanged to user_wr_addr/user_rd_addr; no alignment check.

## Test plan
- AW 0x10 and W 0xDEADBEEF/strb 0xF same cycle, user_wr_resp 0 -> user_wr_en one cycle 2 edges later with addr 0x10, bvalid+bresp 0 next cycle.
- W first, AW 0x20 three cycles later, bready held low 5 cycles -> single user_wr_en, bvalid stable 5 cycles, second AW/W accepted but not fired until B handshake.
- RD_LATENCY=3, read 0x8, user_rd_data 0x12345678 driven 3 cycles after user_rd_en -> rdata 0x12345678, rresp 0, rvalid at E1+3.
- ADDR_SPAN 4096, read 0x2000 and write 0x1000 -> no user strobes, rresp/bresp 2'b11, rdata 0.
- With AXIL_SLV_UNALIGNED_ERR_EN, write 0x6 -> bresp 2'b10, no user_wr_en; without macro -> user_wr_addr 0x6, bresp from user.
- aresetn low for one cycle between user_rd_en and rvalid -> rvalid never asserts, arready 0 during reset then 1.
